adc_scan_ctrl: RTL and testbench
================================

// Module: adc_scan_ctrl
// PURPOSE
//  Parametrised SPI master for ADC128S022-class 8-ch serial ADCs. Successor to the single-channel
//  controller: one system clock with internal SCLK divider, multi-channel scan by mask, single-shot
//  or continuous modes, channel-tagged valid strobe. Sits between the ADC pins and the estimator.
// PARAMETERS
//  CLK_DIV     8   SCLK half-period in iCLK cycles (>=1); 50 MHz/16 = 3.125 MHz
//  NUM_CH      8   channels scanned, 1..8; mask width
//  DATA_W      12  result bits per frame, 1..(FRAME_BITS-DOUT_FIRST)
//  FRAME_BITS  16  SCLK cycles per frame
//  ADDR_FIRST  2   SCLK index carrying ADD2; ADD1, ADD0 follow
//  DOUT_FIRST  4   SCLK index of result MSB
// PORTS
//  iCLK      in   1        system clock; all logic on posedge
//  iRST      in   1        asynchronous, active-low reset
//  iGO       in   1        start pulse; honoured only in IDLE
//  iCONT     in   1        1 = continuous scan, 0 = one pass; sampled at start, then as stop request
//  iCH_MASK  in   NUM_CH   enabled channels; captured at start
//  oCS_n     out  1        ADC chip select, low for the whole burst
//  oSCLK     out  1        ADC serial clock, idles high
//  oDIN      out  1        ADC address bit stream
//  iDOUT     in   1        ADC serial data
//  oDATA     out  DATA_W   last result, MSB-first assembled
//  oCH       out  3        channel oDATA belongs to
//  oVALID    out  1        1-cycle strobe: oDATA/oCH new
//  oBUSY     out  1        high from accepted iGO until return to IDLE
//  oERR      out  1        1-cycle strobe: iGO with empty mask
// BEHAVIOUR
//  Reset (async, any time): oCS_n=1, oSCLK=1, oDIN=0, oDATA=0, oCH=0, oVALID=0, oBUSY=0, oERR=0;
//   FSM->IDLE, counters 0, partial frame discarded, no oVALID.
//  FSM: IDLE -> SETUP (oCS_n=0, CLK_DIV cycles, SCLK high) -> SHIFT (FRAME_BITS SCLK cycles)
//   -> SHIFT again while frames remain, else DONE (SCLK high, CLK_DIV cycles) -> IDLE, oCS_n=1.
//  SCLK: each SCLK cycle = falling tick then rising tick, CLK_DIV iCLK apart; frame = 2*CLK_DIV*FRAME_BITS.
//  oDIN updates on falling tick: SCLK idx ADDR_FIRST..+2 = ADD2..ADD0 of next channel, else 0.
//  iDOUT registered on rising tick of idx DOUT_FIRST..DOUT_FIRST+DATA_W-1, MSB first.
//  Pipeline: frame k addresses the channel converted in frame k+1. First frame of a burst is priming:
//   addresses first enabled channel, result dropped. Frame k>=1 result tagged with channel addressed in k-1.
//  Scan order: enabled channels ascending, wrap to lowest enabled. Single-shot: priming + popcount(mask)
//   frames, last frame's address = lowest enabled (don't care). Single-channel mask repeats that channel.
//  oVALID: asserted the iCLK cycle after the final DOUT sample of the frame; oDATA/oCH update same cycle,
//   hold until next oVALID.
//  Continuous: iCONT low during a frame -> that frame completes, result delivered, then DONE.
//  iGO with iCH_MASK==0: oERR pulse next cycle, stay IDLE, oCS_n stays 1. iGO while oBUSY: ignored.
//  iGO and reset together: reset wins.
// STRUCTURE
//  adc_pkg: FSM state encoding, ADDR_W=3, SCLK tick enum, default frame constants.
//  Sub-module adc_sclk_gen: CLK_DIV counter issuing fall/rise tick strobes and oSCLK level; enable from FSM.
//  Top: FSM, bit counter 0..FRAME_BITS-1, channel picker (next enabled after current), shift reg, tag reg.
// TESTING (ADC bus-functional model returns per-channel words, checks ADD bits)
//  1 Reset: hold iRST=0 -> all outputs at reset values; release, no activity without iGO.
//  2 Single-shot mask=8'h05, model ch0=12'hA5C ch2=12'h3F1 -> DIN addr 0,2,0; oVALID (0,A5C) then (2,3F1);
//    no oVALID after priming; oBUSY low, oCS_n=1 after 3 frames.
//  3 Continuous mask=8'h80, ch7=12'h800 -> oVALID oCH=7 every 256 iCLK after priming; drop iCONT mid-frame
//    -> exactly one more oVALID, then IDLE.
//  4 iGO, mask=0 -> oERR single-cycle pulse, oCS_n=1, oBUSY=0 throughout.
//  5 iRST low at SCLK idx 9 of frame 2 -> immediate reset values, no oVALID; next iGO starts with priming.
//  6 Timing: CLK_DIV=8: 16 falling edges/frame, 8-cycle half period, SCLK high between iGO and first fall;
//    iGO pulses while busy produce no extra frames.

Source files
------------

// File: rtl/adc_scan_ctrl_pkg.sv
// Shared types, constants and channel-selection helpers for the ADC scan controller.
package adc_scan_ctrl_pkg;

  localparam int ADDR_W         = 3;
  localparam int DEF_CLK_DIV    = 8;
  localparam int DEF_NUM_CH     = 8;
  localparam int DEF_DATA_W     = 12;
  localparam int DEF_FRAME_BITS = 16;
  localparam int DEF_ADDR_FIRST = 2;
  localparam int DEF_DOUT_FIRST = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef enum logic {
    TICK_FALL = 1'b0,
    TICK_RISE = 1'b1
  } tick_t;

  // Next enabled channel strictly after cur, wrapping; cur=7 yields the lowest enabled one.
  function automatic logic [ADDR_W-1:0] next_ch(input logic [7:0] mask,
                                                input logic [ADDR_W-1:0] cur);
    logic [ADDR_W-1:0] c;
    logic              found;
    next_ch = cur;
    found   = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      c = cur + ADDR_W'(i);
      if (!found && mask[c]) begin
        next_ch = c;
        found   = 1'b1;
      end
    end
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] mask);
    popcount8 = '0;
    for (int i = 0; i < 8; i++) popcount8 = popcount8 + {3'd0, mask[i]};
  endfunction

endpackage

// File: rtl/adc_scan_ctrl_if.sv
// Host and ADC-pin bundle for adc_scan_ctrl, plus an FSM state debug tap.
interface adc_scan_ctrl_if
  import adc_scan_ctrl_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int DATA_W = DEF_DATA_W
);
  // iGO is a one-cycle request taken only while oBUSY is low; oVALID and oERR are
  // one-cycle strobes with no back-pressure, oDATA/oCH hold until the next oVALID.
  logic              iGO;
  logic              iCONT;
  logic [NUM_CH-1:0] iCH_MASK;
  logic              oCS_n;
  logic              oSCLK;
  logic              oDIN;
  logic              iDOUT;
  logic [DATA_W-1:0] oDATA;
  logic [ADDR_W-1:0] oCH;
  logic              oVALID;
  logic              oBUSY;
  logic              oERR;
  state_t            oSTATE;

  modport master (
    output iGO, iCONT, iCH_MASK, iDOUT,
    input  oCS_n, oSCLK, oDIN, oDATA, oCH, oVALID, oBUSY, oERR, oSTATE
  );

  modport slave (
    input  iGO, iCONT, iCH_MASK, iDOUT,
    output oCS_n, oSCLK, oDIN, oDATA, oCH, oVALID, oBUSY, oERR, oSTATE
  );
endinterface

// File: rtl/adc_scan_ctrl_sclk_gen.sv
// SCLK divider: alternating fall/rise tick strobes CLK_DIV cycles apart while enabled.
module adc_sclk_gen
  import adc_scan_ctrl_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
)(
  input  logic iCLK,
  input  logic iRST,
  input  logic i_en,
  input  logic i_fall_en,
  output logic o_fall,
  output logic o_rise,
  output logic o_sclk
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] r_cnt;
  tick_t         r_phase;
  logic          r_sclk;
  logic          w_tick;

  assign w_tick = i_en && (r_cnt == CW'(CLK_DIV - 1));
  assign o_fall = w_tick && (r_phase == TICK_FALL);
  assign o_rise = w_tick && (r_phase == TICK_RISE);
  assign o_sclk = r_sclk;

  // The first tick after enable is always a fall, so SCLK sits high for one half period.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_cnt   <= '0;
      r_phase <= TICK_FALL;
      r_sclk  <= 1'b1;
    end else if (!i_en) begin
      r_cnt   <= '0;
      r_phase <= TICK_FALL;
      r_sclk  <= 1'b1;
    end else if (w_tick) begin
      r_cnt   <= '0;
      r_phase <= (r_phase == TICK_FALL) ? TICK_RISE : TICK_FALL;
      if (o_fall && i_fall_en) r_sclk <= 1'b0;
      if (o_rise)              r_sclk <= 1'b1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/adc_scan_ctrl.sv
// SPI master scanning an 8-channel serial ADC by mask, single-shot or continuous.
module adc_scan_ctrl
  import adc_scan_ctrl_pkg::*;
#(
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FRAME_BITS = DEF_FRAME_BITS,
  parameter int ADDR_FIRST = DEF_ADDR_FIRST,
  parameter int DOUT_FIRST = DEF_DOUT_FIRST
)(
  input  logic            iCLK,
  input  logic            iRST,
  adc_scan_ctrl_if.slave  bus
);
  localparam int BIT_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0] DOUT_LO  = BIT_W'(DOUT_FIRST);
  localparam logic [BIT_W-1:0] DOUT_HI  = BIT_W'(DOUT_FIRST + DATA_W - 1);

  state_t            r_state;
  logic [BIT_W-1:0]  r_bit;
  logic [NUM_CH-1:0] r_mask;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_tag;
  logic              r_prime;
  logic              r_cont;
  logic              r_stop;
  logic [3:0]        r_left;
  logic [DATA_W-1:0] r_shift;
  logic              r_cs_n;
  logic              r_din;
  logic [DATA_W-1:0] r_data;
  logic [ADDR_W-1:0] r_ch;
  logic              r_valid;
  logic              r_busy;
  logic              r_err;

  logic              w_fall;
  logic              w_rise;
  logic              w_sclk;
  logic              w_sclk_en;
  logic              w_fall_en;
  logic [7:0]        w_mask8;
  logic [7:0]        w_go_mask8;
  logic [ADDR_W-1:0] w_next;
  logic [ADDR_W-1:0] w_first;
  logic              w_addr_bit;
  logic              w_in_dout;
  logic              w_stop;
  logic [DATA_W-1:0] w_shift_nx;

  assign w_sclk_en = (r_state != ST_IDLE);
  assign w_fall_en = (r_state != ST_DONE);

  adc_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .iCLK      (iCLK),
    .iRST      (iRST),
    .i_en      (w_sclk_en),
    .i_fall_en (w_fall_en),
    .o_fall    (w_fall),
    .o_rise    (w_rise),
    .o_sclk    (w_sclk)
  );

  always_comb begin
    w_mask8    = '0;
    w_go_mask8 = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_mask8[i]    = r_mask[i];
      w_go_mask8[i] = bus.iCH_MASK[i];
    end
  end

  assign w_next  = next_ch(w_mask8, r_addr);
  assign w_first = next_ch(w_go_mask8, {ADDR_W{1'b1}});

  // Address bits go out MSB first over the ADDR_W SCLK cycles starting at ADDR_FIRST.
  always_comb begin
    w_addr_bit = 1'b0;
    for (int i = 0; i < ADDR_W; i++) begin
      if (r_bit == BIT_W'(ADDR_FIRST + i)) w_addr_bit = r_addr[ADDR_W-1-i];
    end
  end

  assign w_in_dout  = (r_bit >= DOUT_LO) && (r_bit <= DOUT_HI);
  assign w_shift_nx = DATA_W'({r_shift, bus.iDOUT});
  assign w_stop     = r_cont ? (r_stop || !bus.iCONT) : (r_left == 4'd0);

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_state <= ST_IDLE;
      r_bit   <= '0;
      r_mask  <= '0;
      r_addr  <= '0;
      r_tag   <= '0;
      r_prime <= 1'b0;
      r_cont  <= 1'b0;
      r_stop  <= 1'b0;
      r_left  <= '0;
      r_shift <= '0;
      r_cs_n  <= 1'b1;
      r_din   <= 1'b0;
      r_data  <= '0;
      r_ch    <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.iGO) begin
            if (w_go_mask8 == 8'h00) begin
              r_err <= 1'b1;
            end else begin
              r_state <= ST_SETUP;
              r_cs_n  <= 1'b0;
              r_busy  <= 1'b1;
              r_mask  <= bus.iCH_MASK;
              r_cont  <= bus.iCONT;
              r_stop  <= 1'b0;
              r_left  <= popcount8(w_go_mask8);
              r_addr  <= w_first;
              r_prime <= 1'b1;
              r_bit   <= '0;
              r_din   <= 1'b0;
            end
          end
        end
        ST_SETUP: begin
          if (w_fall) begin
            r_state <= ST_SHIFT;
            r_din   <= w_addr_bit;
          end
        end
        ST_SHIFT: begin
          if (!bus.iCONT) r_stop <= 1'b1;
          if (w_fall) r_din <= w_addr_bit;
          if (w_rise) begin
            if (w_in_dout) r_shift <= w_shift_nx;
            // The priming frame converts an unknown channel, so its result is dropped.
            if ((r_bit == DOUT_HI) && !r_prime) begin
              r_data  <= w_shift_nx;
              r_ch    <= r_tag;
              r_valid <= 1'b1;
            end
            if (r_bit == LAST_BIT) begin
              r_bit   <= '0;
              r_prime <= 1'b0;
              r_tag   <= r_addr;
              r_addr  <= w_next;
              if (r_left != 4'd0) r_left <= r_left - 4'd1;
              if (w_stop) r_state <= ST_DONE;
            end else begin
              r_bit <= r_bit + 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (w_fall) begin
            r_state <= ST_IDLE;
            r_cs_n  <= 1'b1;
            r_busy  <= 1'b0;
            r_din   <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.oCS_n  = r_cs_n;
  assign bus.oSCLK  = w_sclk;
  assign bus.oDIN   = r_din;
  assign bus.oDATA  = r_data;
  assign bus.oCH    = r_ch;
  assign bus.oVALID = r_valid;
  assign bus.oBUSY  = r_busy;
  assign bus.oERR   = r_err;
  assign bus.oSTATE = r_state;

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Bench for adc_scan_ctrl: ADC pin model, table of scan jobs, random jobs and directed corners.
module tb_adc_scan_ctrl;
  import adc_scan_ctrl_pkg::*;

  localparam int CLK_DIV    = 8;
  localparam int FRAME_BITS = 16;
  localparam int PERIOD     = 2 * CLK_DIV * FRAME_BITS;

  logic clk;
  logic rst_n;

  adc_scan_ctrl_if #(.NUM_CH(8), .DATA_W(12)) bus ();

  adc_scan_ctrl dut (
    .iCLK (clk),
    .iRST (rst_n),
    .bus  (bus)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [11:0] adc_word [8];

  logic [14:0] obs_word [512];
  int          obs_t    [512];
  int          obs_n    = 0;
  int          err_n    = 0;
  int          err_wide = 0;
  int          cyc      = 0;
  logic        prev_err = 1'b0;

  logic [2:0]  obs_addr [512];
  int          addr_n   = 0;
  int          frame_n  = 0;
  int          fall_n   = 0;
  int          cur_idx  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Output monitor: collects every strobe with a cycle stamp.
  always @(negedge clk) begin
    if (bus.oVALID === 1'b1 && obs_n < 512) begin
      obs_word[obs_n] = {bus.oCH, bus.oDATA};
      obs_t[obs_n]    = cyc;
      obs_n++;
    end
    if (bus.oERR === 1'b1) begin
      err_n++;
      if (prev_err) err_wide++;
    end
    prev_err = (bus.oERR === 1'b1);
    cyc++;
  end

  // ADC pin model: converts the channel addressed in the previous frame of the burst.
  initial begin : adc_bfm
    logic       prev_cs, prev_sclk, have_last;
    logic [2:0] rx_addr, last_addr;
    logic [11:0] cur_word;
    int         fidx;
    bus.iDOUT = 1'b0;
    prev_cs = 1'b1; prev_sclk = 1'b1; have_last = 1'b0;
    rx_addr = '0; last_addr = '0; cur_word = '0; fidx = 0;
    forever begin
      @(bus.oSCLK or bus.oCS_n);
      if (prev_cs === 1'b1 && bus.oCS_n === 1'b0) begin
        fidx = 0;
        have_last = 1'b0;
      end else if (bus.oCS_n === 1'b0 && prev_sclk === 1'b1 && bus.oSCLK === 1'b0) begin
        cur_idx = fidx % FRAME_BITS;
        if (cur_idx == 0) begin
          frame_n++;
          cur_word = have_last ? adc_word[last_addr] : 12'hFFF;
        end
        fall_n++;
        bus.iDOUT = (cur_idx >= 4) ? cur_word[15 - cur_idx] : 1'b0;
        fidx++;
      end else if (bus.oCS_n === 1'b0 && prev_sclk === 1'b0 && bus.oSCLK === 1'b1) begin
        if (cur_idx >= 2 && cur_idx <= 4) rx_addr = {rx_addr[1:0], bus.oDIN};
        if (cur_idx == 4) begin
          if (addr_n < 512) obs_addr[addr_n] = rx_addr;
          addr_n++;
          last_addr = rx_addr;
          have_last = 1'b1;
        end
      end
      prev_cs   = bus.oCS_n;
      prev_sclk = bus.oSCLK;
    end
  end

  // ---------------- reference model ----------------
  function automatic int build_list(input logic [7:0] m, output int l [8]);
    int p = 0;
    for (int i = 0; i < 8; i++) l[i] = 0;
    for (int c = 0; c < 8; c++) if (m[c]) begin l[p] = c; p++; end
    return p;
  endfunction

  task automatic check_reset_vals(input string name);
    check(name, {bus.oCS_n, bus.oSCLK, bus.oDIN, bus.oDATA, bus.oCH, bus.oVALID, bus.oBUSY, bus.oERR},
          {2'b11, 19'd0});
    check({name, "_state"}, 32'(bus.oSTATE), 32'(ST_IDLE));
  endtask

  // Runs one job and checks addresses, results and spacing against the model.
  task automatic run_job(input logic [7:0] mask, input logic cont, input int stop_frame,
                         output int frames, output int valids, output int errs);
    int v0, f0, a0, e0, w, bad, p;
    int l [8];
    v0 = obs_n; f0 = frame_n; a0 = addr_n; e0 = err_n;
    @(negedge clk);
    bus.iCH_MASK = mask; bus.iCONT = cont; bus.iGO = 1'b1;
    @(negedge clk);
    bus.iGO = 1'b0;
    if (mask == 8'h00) begin
      bad = 0;
      repeat (20) begin
        @(negedge clk);
        if (bus.oBUSY !== 1'b0 || bus.oCS_n !== 1'b1) bad++;
      end
      check("err_idle", bad, 0);
    end else begin
      if (cont) begin
        w = 0;
        while (frame_n - f0 < stop_frame + 1 && w < 3000) begin @(negedge clk); w++; end
        check("cont_wait", 32'(w < 3000), 1);
        repeat ($urandom_range(10, 200)) @(negedge clk);
        bus.iCONT = 1'b0;
      end
      w = 0;
      while (bus.oBUSY === 1'b1 && w < 6000) begin @(negedge clk); w++; end
      check("busy_end", 32'(bus.oBUSY), 0);
      check("cs_end", 32'(bus.oCS_n), 1);
    end
    bus.iCONT = 1'b0;
    repeat (4) @(negedge clk);
    frames = frame_n - f0;
    valids = obs_n - v0;
    errs   = err_n - e0;
    p = build_list(mask, l);
    if (p > 0) begin
      for (int i = 0; i < frames && a0 + i < addr_n; i++)
        check("addr", obs_addr[a0 + i], l[i % p]);
      for (int i = 0; i < valids; i++) begin
        check("result", obs_word[v0 + i], {3'(l[i % p]), adc_word[l[i % p]]});
        if (i > 0) check("spacing", obs_t[v0 + i] - obs_t[v0 + i - 1], PERIOD);
      end
    end
  endtask

  typedef struct {
    logic [7:0] mask;
    logic       cont;
    int         stop_frame;
    int         exp_err;
    int         exp_frames;
    int         exp_valids;
  } vec_t;

  vec_t vecs [7];

  initial begin : main
    int frames, valids, errs, v0, f0, fl0, a0, n, w, p;
    int l [8];
    logic [7:0] m;
    logic       c;
    int         sf;

    vecs[0] = '{8'h05, 1'b0, 0, 0, 3, 2};
    vecs[1] = '{8'h00, 1'b0, 0, 1, 0, 0};
    vecs[2] = '{8'h80, 1'b1, 4, 0, 5, 4};
    vecs[3] = '{8'hFF, 1'b0, 0, 0, 9, 8};
    vecs[4] = '{8'h12, 1'b0, 0, 0, 3, 2};
    vecs[5] = '{8'h01, 1'b1, 2, 0, 3, 2};
    vecs[6] = '{8'h00, 1'b1, 0, 1, 0, 0};

    adc_word[0] = 12'hA5C; adc_word[1] = 12'h1B7; adc_word[2] = 12'h3F1; adc_word[3] = 12'h0C4;
    adc_word[4] = 12'hF0F; adc_word[5] = 12'h555; adc_word[6] = 12'hAAA; adc_word[7] = 12'h800;

    // reset
    rst_n = 1'b0; bus.iGO = 1'b0; bus.iCONT = 1'b0; bus.iCH_MASK = '0;
    repeat (5) @(negedge clk);
    check_reset_vals("reset_hold");
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    check_reset_vals("idle_no_go");
    check("idle_frames", frame_n, 0);
    check("idle_valids", obs_n, 0);

    // spec scenario: mask 05, exact timing, iGO while busy ignored
    v0 = obs_n; f0 = frame_n; fl0 = fall_n; a0 = addr_n;
    @(negedge clk);
    bus.iCH_MASK = 8'h05; bus.iCONT = 1'b0; bus.iGO = 1'b1;
    n = 0;
    while (n < 100) begin
      @(posedge clk); #1; n++;
      if (n == 1) bus.iGO = 1'b0;
      if (bus.oSCLK === 1'b0) break;
    end
    check("go_to_first_fall", n - 1, CLK_DIV);
    n = 0;
    while (n < 100) begin @(posedge clk); #1; n++; if (bus.oSCLK === 1'b1) break; end
    check("sclk_low_half", n, CLK_DIV);
    n = 0;
    while (n < 100) begin @(posedge clk); #1; n++; if (bus.oSCLK === 1'b0) break; end
    check("sclk_high_half", n, CLK_DIV);
    for (int k = 0; k < 3; k++) begin
      repeat (150) @(negedge clk);
      bus.iGO = 1'b1;
      @(negedge clk);
      bus.iGO = 1'b0;
    end
    w = 0;
    while (bus.oBUSY === 1'b1 && w < 6000) begin @(negedge clk); w++; end
    repeat (40) @(negedge clk);
    check("t2_busy", 32'(bus.oBUSY), 0);
    check("t2_cs", 32'(bus.oCS_n), 1);
    check("t2_frames", frame_n - f0, 3);
    check("t2_falls", fall_n - fl0, 3 * FRAME_BITS);
    check("t2_valids", obs_n - v0, 2);
    check("t2_addr0", obs_addr[a0], 0);
    check("t2_addr1", obs_addr[a0 + 1], 2);
    check("t2_addr2", obs_addr[a0 + 2], 0);
    check("t2_res0", obs_word[v0], {3'd0, 12'hA5C});
    check("t2_res1", obs_word[v0 + 1], {3'd2, 12'h3F1});

    // job table
    for (int i = 0; i < 7; i++) begin
      run_job(vecs[i].mask, vecs[i].cont, vecs[i].stop_frame, frames, valids, errs);
      check($sformatf("vec%0d_err", i), errs, vecs[i].exp_err);
      check($sformatf("vec%0d_frames", i), frames, vecs[i].exp_frames);
      check($sformatf("vec%0d_valids", i), valids, vecs[i].exp_valids);
    end

    // reset at SCLK index 9 of frame 2
    v0 = obs_n; f0 = frame_n;
    @(negedge clk);
    bus.iCH_MASK = 8'hFF; bus.iCONT = 1'b0; bus.iGO = 1'b1;
    @(negedge clk);
    bus.iGO = 1'b0;
    w = 0;
    while (!(frame_n - f0 == 3 && cur_idx == 9) && w < 3000) begin @(negedge clk); w++; end
    check("rst_mid_reach", 32'(w < 3000), 1);
    rst_n = 1'b0;
    #1;
    check_reset_vals("rst_mid_immediate");
    check("rst_mid_prior_valids", obs_n - v0, 1);
    check("rst_mid_prior_res", obs_word[v0], {3'd0, 12'hA5C});
    repeat (5) @(negedge clk);
    check("rst_mid_no_valid", obs_n - v0, 1);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    run_job(8'h05, 1'b0, 0, frames, valids, errs);
    check("after_rst_frames", frames, 3);
    check("after_rst_valids", valids, 2);

    // random jobs against the model
    for (int r = 0; r < 10; r++) begin
      for (int ch = 0; ch < 8; ch++) adc_word[ch] = 12'($urandom_range(0, 4095));
      m  = 8'($urandom_range(1, 255));
      c  = 1'($urandom_range(0, 1));
      sf = $urandom_range(0, 3);
      p  = build_list(m, l);
      run_job(m, c, sf, frames, valids, errs);
      check("rnd_frames", frames, c ? sf + 1 : p + 1);
      check("rnd_valids", valids, c ? sf : p);
      check("rnd_err", errs, 0);
    end

    check("err_single_cycle", err_wide, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
